// File: rtl/lcd_bus_sequencer.sv
// Turns one EPC access into one timed HD44780 bus cycle (setup, EN pulse, hold, recovery) and holds the EPC off via RDY.
// Optional: define LCD_LONG_CMD_WAIT_EN to stretch recovery to T_LONG after clear/home commands.
module lcd_bus_sequencer #(
  parameter int T_SETUP   = 3,
  parameter int T_EN_HIGH = 12,
  parameter int T_HOLD    = 2,
  parameter int T_RECOVER = 25,
  parameter int T_LONG    = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nCS,
  input  logic       nWR,
  input  logic       nRD,
  input  logic       rs_sel,
  input  logic [7:0] wr_data,
  input  logic [7:0] lcd_din,
  output logic [7:0] lcd_dout,
  output logic       lcd_oe,
  output logic       RS,
  output logic       RW,
  output logic       EN,
  output logic [7:0] rd_data,
  output logic       RDY
);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, RECOVER, DONE} state_e;

  localparam logic [16:0] SETUP_LD   = 17'(T_SETUP - 1);
  localparam logic [16:0] EN_LD      = 17'(T_EN_HIGH - 1);
  localparam logic [16:0] HOLD_LD    = 17'(T_HOLD - 1);
  localparam logic [16:0] RECOVER_LD = 17'(T_RECOVER - 1);
  localparam logic [16:0] LONG_LD    = 17'(T_LONG - 1);

`ifdef LCD_LONG_CMD_WAIT_EN
  localparam bit LONG_WAIT_EN = 1'b1;
`else
  localparam bit LONG_WAIT_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic        rs_q, rs_d, rw_q, rw_d, oe_q, oe_d, en_q, en_d;
  logic        abort_q, abort_d;
  logic [7:0]  dout_q, dout_d, rd_q, rd_d;
  logic        req, long_cmd;
  logic [16:0] recover_ld;

  assign req = !nCS && (!nWR || !nRD);

  // Clear (0x01) and home (0x02/0x03) are the only slow HD44780 commands.
  assign long_cmd   = !rw_q && !rs_q && (dout_q inside {8'h01, 8'h02, 8'h03});
  assign recover_ld = (LONG_WAIT_EN && long_cmd) ? LONG_LD : RECOVER_LD;

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    rd_d    = rd_q;
    abort_d = abort_q;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          rs_d    = rs_sel;
          rw_d    = nWR;
          dout_d  = wr_data;
          oe_d    = !nWR;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        abort_d = abort_q || !req;
        if (cnt_q == '0) begin
          cnt_d   = EN_LD;
          state_d = EN_HI;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      EN_HI: begin
        abort_d = abort_q || !req;
        if (cnt_q == '0) begin
          if (rw_q) rd_d = lcd_din;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      HOLD: begin
        abort_d = abort_q || !req;
        if (cnt_q == '0) begin
          oe_d    = 1'b0;
          cnt_d   = recover_ld;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      RECOVER: begin
        abort_d = abort_q || !req;
        if (cnt_q == '0) begin
          // A strobe that went away mid-cycle never gets a DONE handshake.
          state_d = (abort_q || !req) ? IDLE : DONE;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    en_d = (state_d == EN_HI);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      en_q    <= 1'b0;
      dout_q  <= 8'h00;
      rd_q    <= 8'h00;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      abort_q <= abort_d;
    end
  end

  assign RS       = rs_q;
  assign RW       = rw_q;
  assign EN       = en_q;
  assign lcd_oe   = oe_q;
  assign lcd_dout = dout_q;
  assign rd_data  = rd_q;
  assign RDY      = ((state_q == IDLE) && !req) || (state_q == DONE);

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboard bench for lcd_bus_sequencer: the driver queues the expected bus cycle, the monitor measures what the pins did.
module tb_lcd_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst, nCS, nWR, nRD, rs_sel;
  logic [7:0] wr_data, lcd_din;
  logic [7:0] lcd_dout, rd_data;
  logic       lcd_oe, RS, RW, EN, RDY;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LCD_LONG_CMD_WAIT_EN
  localparam bit LONG = 1'b1;
`else
  localparam bit LONG = 1'b0;
`endif

  typedef struct {
    logic       rs, rw, oe, chk_dout;
    logic [7:0] dout, rd;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_rd = 8'h00;

  lcd_bus_sequencer dut (
    .clk(clk), .rst(rst), .nCS(nCS), .nWR(nWR), .nRD(nRD), .rs_sel(rs_sel),
    .wr_data(wr_data), .lcd_din(lcd_din), .lcd_dout(lcd_dout), .lcd_oe(lcd_oe),
    .RS(RS), .RW(RW), .EN(EN), .rd_data(rd_data), .RDY(RDY)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One EPC access; abort_at > 0 releases the strobe after that many edges.
  task automatic do_access(input bit wr, input bit rs, input logic [7:0] d,
                           input logic [7:0] din, input int abort_at);
    exp_t e;
    bit   done = 1'b0;
    int   budget;
    e.rs = rs; e.rw = !wr; e.oe = wr; e.chk_dout = wr; e.dout = d;
    if (!wr) last_rd = din;
    e.rd  = last_rd;
    e.lat = (LONG && wr && !rs && (d inside {8'h01, 8'h02, 8'h03})) ? 76018 : 43;
    budget = e.lat + 20;
    sb.push_back(e);
    @(posedge clk); #1;
    nCS = 1'b0; nWR = !wr; nRD = wr; rs_sel = rs; wr_data = d; lcd_din = din;
    #1 check("rdy_drop", 32'(RDY), 32'd0);
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1 nCS = 1'b1; nWR = 1'b1; nRD = 1'b1;
    end
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (RDY) begin done = 1'b1; break; end
    end
    if (!done) check("rdy_timeout", 32'(done), 32'd1);
    nCS = 1'b1; nWR = 1'b1; nRD = 1'b1;
  endtask

  // Monitor: cycle 0 is the first sample with RDY low; a transaction closes when RDY returns high.
  initial begin : monitor
    bit         in_acc = 1'b0;
    int         cyc = 0, en_rise = -1, en_w = 0;
    logic       rs_c = 1'b0, rw_c = 1'b0, oe_c = 1'b0;
    logic [7:0] dout_c = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_acc = 1'b0;
      end else if (!in_acc) begin
        if (!RDY) begin
          in_acc = 1'b1; cyc = 0; en_rise = -1; en_w = 0;
        end
      end else begin
        cyc++;
        if (EN) begin
          if (en_rise < 0) begin
            en_rise = cyc; rs_c = RS; rw_c = RW; oe_c = lcd_oe; dout_c = lcd_dout;
          end
          en_w++;
        end
        if (RDY) begin
          in_acc = 1'b0;
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            check("latency", 32'(cyc), 32'(e.lat));
            check("en_rise", 32'(en_rise), 32'd4);
            check("en_width", 32'(en_w), 32'd12);
            check("rs", 32'(rs_c), 32'(e.rs));
            check("rw", 32'(rw_c), 32'(e.rw));
            check("oe_during_en", 32'(oe_c), 32'(e.oe));
            if (e.chk_dout) check("lcd_dout", 32'(dout_c), 32'(e.dout));
            check("rd_data", 32'(rd_data), 32'(e.rd));
            check("oe_after_hold", 32'(lcd_oe), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; nCS = 1'b1; nWR = 1'b1; nRD = 1'b1; rs_sel = 1'b0;
    wr_data = 8'h00; lcd_din = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", 32'(EN), 32'd0);
    check("rst_rs", 32'(RS), 32'd0);
    check("rst_rw", 32'(RW), 32'd0);
    check("rst_oe", 32'(lcd_oe), 32'd0);
    check("rst_dout", 32'(lcd_dout), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_rdy", 32'(RDY), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    do_access(1'b1, 1'b0, 8'h38, 8'h00, 0);  // function set
    do_access(1'b1, 1'b1, 8'h41, 8'h00, 0);  // 'A'
    do_access(1'b0, 1'b0, 8'h00, 8'h80, 0);  // busy flag read
    do_access(1'b1, 1'b0, 8'h01, 8'h00, 0);  // clear display
    do_access(1'b1, 1'b0, 8'h0C, 8'h00, 10); // strobe dropped mid-cycle
    do_access(1'b0, 1'b1, 8'h00, 8'h5A, 0);  // data read after abort
    do_access(1'b1, 1'b1, 8'h42, 8'h00, 0);  // rd_data must stay 0x5A

    // Reset while EN is high: drop everything on the next edge.
    @(posedge clk); #1;
    nCS = 1'b0; nWR = 1'b0; nRD = 1'b1; rs_sel = 1'b1; wr_data = 8'h55;
    repeat (8) @(posedge clk);
    #1 check("pre_rst_en", 32'(EN), 32'd1);
    rst = 1'b0; nCS = 1'b1; nWR = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_en", 32'(EN), 32'd0);
    check("mid_rst_rs", 32'(RS), 32'd0);
    check("mid_rst_oe", 32'(lcd_oe), 32'd0);
    check("mid_rst_rdy", 32'(RDY), 32'd1);
    check("mid_rst_rd", 32'(rd_data), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    last_rd = 8'h00;
    do_access(1'b1, 1'b0, 8'h06, 8'h00, 0);  // entry mode after reset

    repeat (5) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
